// File: rtl/sequence_feed_ctrl.sv
// rtl/sequence_feed_ctrl.sv - serial feeder/collector for a one-bit Moore sequence detector
// Optional first-hit tracking enabled by defining SEQ_FEED_FIRST_HIT_EN.
module sequence_feed_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  len,
  input  logic              det_hit,
  output logic              det_w,
  output logic              det_en,
  output logic              det_clr,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  first_hit,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_SHIFT  = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [CNT_W-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(DATA_W);

  logic [2:0]        state_q;
  logic [2:0]        state_d;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [CNT_W-1:0]  hit_count_q;
  logic [CNT_W-1:0]  len_clamped;
  logic              accept;

  assign len_clamped = ((len == '0) || (len > MAX_LEN)) ? MAX_LEN : len;
  assign accept      = (state_q == S_IDLE) && start && !abort;

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every non-idle transition
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = accept ? S_CLEAR : S_IDLE;
      S_CLEAR:  state_d = S_SHIFT;
      S_SHIFT:  state_d = S_SAMPLE;
      S_SAMPLE: state_d = (remaining_q == CNT_W'(1)) ? S_DONE : S_SHIFT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && abort) begin
      state_d = S_IDLE;
    end
  end

  // Outputs decoded from the state register only
  always_comb begin
    busy    = (state_q != S_IDLE);
    done    = (state_q == S_DONE);
    det_en  = (state_q == S_SHIFT);
    det_clr = (state_q == S_CLEAR);
    det_w   = (state_q == S_SHIFT) && shift_q[DATA_W-1];
  end

  // The sample of an aborted SAMPLE cycle is still counted, so partial results include it
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shift_q     <= '0;
      remaining_q <= '0;
      hit_count_q <= '0;
    end else begin
      if (accept) begin
        shift_q     <= data_in;
        remaining_q <= len_clamped;
        hit_count_q <= '0;
      end else if (state_q == S_SHIFT) begin
        shift_q <= {shift_q[DATA_W-2:0], 1'b0};
      end else if (state_q == S_SAMPLE) begin
        remaining_q <= remaining_q - CNT_W'(1);
        if (det_hit && (hit_count_q != ALL_ONES)) begin
          hit_count_q <= hit_count_q + CNT_W'(1);
        end
      end
    end
  end

`ifdef SEQ_FEED_FIRST_HIT_EN
  logic [CNT_W-1:0] bit_idx_q;
  logic [CNT_W-1:0] first_hit_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bit_idx_q   <= '0;
      first_hit_q <= ALL_ONES;
    end else begin
      if (accept) begin
        bit_idx_q   <= '0;
        first_hit_q <= ALL_ONES;
      end else if (state_q == S_SAMPLE) begin
        bit_idx_q <= bit_idx_q + CNT_W'(1);
        if (det_hit && (first_hit_q == ALL_ONES)) begin
          first_hit_q <= bit_idx_q;
        end
      end
    end
  end

  assign first_hit = first_hit_q;
`else
  assign first_hit = ALL_ONES;
`endif

  assign hit_count = hit_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_sequence_feed_ctrl.sv
// tb/tb_sequence_feed_ctrl.sv - directed self-checking bench for sequence_feed_ctrl
// Expected first_hit follows SEQ_FEED_FIRST_HIT_EN.
module tb_sequence_feed_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] data_in = '0;
  logic [4:0]  len = '0;
  logic        det_hit;
  logic        det_w;
  logic        det_en;
  logic        det_clr;
  logic        busy;
  logic        done;
  logic [4:0]  hit_count;
  logic [4:0]  first_hit;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_FEED_FIRST_HIT_EN
  localparam logic [4:0] EXP_FH1 = 5'd1;
`else
  localparam logic [4:0] EXP_FH1 = 5'h1F;
`endif

  sequence_feed_ctrl #(.DATA_W(16), .CNT_W(5)) dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .data_in(data_in), .len(len), .det_hit(det_hit),
    .det_w(det_w), .det_en(det_en), .det_clr(det_clr),
    .busy(busy), .done(done), .hit_count(hit_count),
    .first_hit(first_hit), .state(state)
  );

  always #5 clock = ~clock;

  // Detector model: hit when the last two stepped bits were both 1
  logic prev_bit;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prev_bit <= 1'b0;
      det_hit  <= 1'b0;
    end else if (det_clr) begin
      prev_bit <= 1'b0;
      det_hit  <= 1'b0;
    end else if (det_en) begin
      det_hit  <= prev_bit & det_w;
      prev_bit <= det_w;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the falling edge inside the CLEAR cycle (t+1)
  task automatic start_run(input logic [15:0] d, input logic [4:0] l);
    @(negedge clock);
    data_in = d;
    len     = l;
    start   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int cyc0, input int exp_cyc);
    int cyc;
    cyc = cyc0;
    while (done !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check(tag, cyc, exp_cyc);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_state", state, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_det", {det_w, det_en, det_clr}, 3'b000);
    check("rst_hits", hit_count, 5'd0);
    check("rst_first", first_hit, 5'h1F);
    resetn = 1'b1;

    // F000, 16 bits: hits after bits 1..3
    start_run(16'hF000, 5'd16);
    check("f000_clear", {state, det_clr, busy}, {3'd1, 1'b1, 1'b1});
    @(negedge clock);
    check("f000_shift0", {state, det_en, det_w}, {3'd2, 1'b1, 1'b1});
    wait_done("f000_lat", 2, 34);
    check("f000_hits", hit_count, 5'd3);
    check("f000_first", first_hit, EXP_FH1);
    @(negedge clock);
    check("f000_idle", {state, done, busy}, {3'd0, 1'b0, 1'b0});
    repeat (2) @(negedge clock);
    check("f000_hold", {hit_count, first_hit}, {5'd3, EXP_FH1});

    // 5555, 8 bits: never two consecutive ones
    start_run(16'h5555, 5'd8);
    wait_done("5555_lat", 1, 18);
    check("5555_hits", hit_count, 5'd0);
    check("5555_first", first_hit, 5'h1F);

    // FFFF, len 0 clamps to 16
    start_run(16'hFFFF, 5'd0);
    wait_done("ffff_lat", 1, 34);
    check("ffff_hits", hit_count, 5'd15);
    check("ffff_first", first_hit, EXP_FH1);

    // Abort in the 5th SAMPLE, with start held high during the run
    start_run(16'hFFFF, 5'd16);
    repeat (2) @(negedge clock);
    start   = 1'b1;
    data_in = 16'h0000;
    repeat (7) @(negedge clock);
    check("abort_pre_state", state, 3'd2);
    check("abort_pre_hits", hit_count, 5'd3);
    @(negedge clock);
    check("abort_sample5", state, 3'd3);
    abort = 1'b1;
    start = 1'b0;
    @(negedge clock);
    abort = 1'b0;
    check("abort_idle", {state, done, busy, det_en, det_clr}, {3'd0, 4'b0000});
    check("abort_hits", hit_count, 5'd4);
    check("abort_first", first_hit, EXP_FH1);
    @(negedge clock);
    check("abort_no_queue", {state, done}, {3'd0, 1'b0});

    // Normal run after abort
    start_run(16'hF000, 5'd16);
    wait_done("post_abort_lat", 1, 34);
    check("post_abort_hits", hit_count, 5'd3);

    // Reset asserted mid-SHIFT
    start_run(16'hFFFF, 5'd16);
    repeat (7) @(negedge clock);
    check("pre_rst_shift", {state, hit_count}, {3'd2, 5'd2});
    resetn = 1'b0;
    #1;
    check("mid_rst_state", state, 3'd0);
    check("mid_rst_det_en", det_en, 1'b0);
    check("mid_rst_hits", hit_count, 5'd0);
    check("mid_rst_first", first_hit, 5'h1F);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("post_rst_idle", {state, busy}, {3'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_feed_ctrl.md
# sequence_feed_ctrl

Controller that serially drives a one-bit Moore sequence detector from a parallel pattern word and collects the results. It captures a word on a start handshake and clears the detector. It then steps the detector one bit at a time, MSB first, and samples the detector's output after each step. It reports the hit count, the index of the first hit and a completion pulse. It sits between switch/host logic and the detector instance, and exposes its state for LED display.

## Interface
- DATA_W, 16, width of pattern word; max bits fed per run
- CNT_W, 5, width of len, hit_count and first_hit; must satisfy 2^CNT_W > DATA_W
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  run request; accepted only in IDLE
- abort  in  1  cancel run; priority over start
- data_in  in  DATA_W  pattern word, captured on accepted start
- len  in  CNT_W  bits to feed, captured on accepted start; 0 or >DATA_W clamps to DATA_W
- det_hit  in  1  detector output (Moore, valid the cycle after a step)
- det_w  out  1  serial bit to detector input
- det_en  out  1  detector step strobe
- det_clr  out  1  detector synchronous clear
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- hit_count  out  CNT_W  number of sampled hits in last/current run
- first_hit  out  CNT_W  0-based bit index of first hit; all-ones if none
- state  out  3  current state encoding, for LED display

## Operation
- States: IDLE=3'd0, CLEAR=3'd1, SHIFT=3'd2, SAMPLE=3'd3, DONE=3'd4; other encodings go to IDLE next cycle.
- IDLE: start=1 and abort=0 → capture data_in into shift register, clamped len into remaining, clear hit_count, set first_hit to all-ones, zero bit index → CLEAR.
- CLEAR: det_clr=1 for exactly one cycle → SHIFT.
- SHIFT: det_en=1, det_w = shift register MSB; shift left by one; → SAMPLE.
- SAMPLE: if det_hit=1, increment hit_count (saturate at all-ones) and load first_hit with bit index if still all-ones. Then increment bit index and decrement remaining. If remaining becomes 0 → DONE, else → SHIFT.
- DONE: done=1 → IDLE.
- abort=1 in any non-IDLE state → IDLE next cycle, no done pulse, no det_en/det_clr that cycle, hit_count/first_hit hold partial values.
- start in any state other than IDLE is ignored (no queuing).
- det_w=0, det_en=0, det_clr=0 outside SHIFT/CLEAR respectively.

## Timing
- Reset (async): state=IDLE, busy=0, done=0, det_w=0, det_en=0, det_clr=0, hit_count=0, first_hit=all-ones, internal registers 0.
- All outputs registered or decoded from state register only; no combinational path from inputs to outputs.
- Start sampled at edge t: CLEAR during t+1; bit k SHIFT at t+2+2k, SAMPLE at t+3+2k; done high during t+2+2n for n bits.
- Run of n bits occupies 2n+2 busy cycles; next start accepted at earliest the cycle after done.
- hit_count/first_hit stable from DONE until next accepted start.

## Configuration
- SEQ_FEED_FIRST_HIT_EN defined: first_hit tracking as above.
- Undefined: first_hit tied to all-ones constant, no first-hit register; all other behaviour identical.

## Test plan
Bench detector model: det_hit=1 when last two stepped bits are both 1; cleared by det_clr.
- Reset mid-SHIFT (resetn low 1 cycle) → state=0, hit_count=0, first_hit=5'h1F, det_en=0 immediately.
- data_in=16'hF000, len=16 → hits after bits 1,2,3; hit_count=3, first_hit=1, done exactly 34 cycles after start edge.
- data_in=16'h5555, len=8 → hit_count=0, first_hit=5'h1F, done at 18 cycles.
- data_in=16'hFFFF, len=0 → clamped to 16; hit_count=15, first_hit=1.
- Abort in 5th SAMPLE of 16'hFFFF run → IDLE next cycle, no done, hit_count=4; start held during run ignored; new start in IDLE runs normally.
- Build without SEQ_FEED_FIRST_HIT_EN, repeat 16'hF000 case → hit_count=3, first_hit=5'h1F.
